// File: rtl/cell_stim_sequencer_pkg.sv
// Shared types, constants and the OAI221 reference function for the stimulus sequencer.
package cell_stim_sequencer_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam int unsigned NUM_VECTORS = 32;

    // stim[0..4] = IN1..IN5
    function automatic logic oai221_exp(logic [4:0] s);
        return ~((s[0] | s[1]) & s[4] & (s[2] | s[3]));
    endfunction

endpackage

// File: rtl/cell_stim_sequencer_if.sv
// Control, stimulus and result signals between the test controller and the sequencer.
interface cell_stim_sequencer_if #(
    parameter int unsigned CNT_W = 16
) ();
    logic             start;
    logic             abort;
    logic             gray_mode;
    logic [3:0]       num_passes;
    logic [4:0]       stim;
    logic             dut_qn;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] mismatch_cnt;
    logic [CNT_W-1:0] toggle_cnt;

    // master: controller plus the cell under test; slave: the sequencer
    modport master (
        output start, abort, gray_mode, num_passes, dut_qn,
        input  stim, busy, done, mismatch_cnt, toggle_cnt
    );

    modport slave (
        input  start, abort, gray_mode, num_passes, dut_qn,
        output stim, busy, done, mismatch_cnt, toggle_cnt
    );
endinterface

// File: rtl/cell_stim_vecgen.sv
// Vector index, binary/Gray mapping and pass counting for the stimulus sequencer.
module cell_stim_vecgen
    import cell_stim_sequencer_pkg::*;
(
    input  logic       CLK,
    input  logic       RSTB,
    input  logic       clear,
    input  logic       step,
    input  logic       gray_in,
    input  logic [3:0] passes_in,
    output logic [4:0] vec,
    output logic       last_vector,
    output logic       last_pass
);
    logic [4:0] idx_q, idx_d;
    logic [3:0] pass_q, pass_d;
    logic [3:0] last_pass_q, last_pass_d;
    logic       gray_q, gray_d;

    assign last_vector = (idx_q == 5'(NUM_VECTORS - 1));
    assign last_pass   = (pass_q == last_pass_q);
    assign vec         = gray_q ? (idx_q ^ (idx_q >> 1)) : idx_q;

    always_comb begin
        idx_d       = idx_q;
        pass_d      = pass_q;
        gray_d      = gray_q;
        last_pass_d = last_pass_q;
        if (clear) begin
            idx_d       = '0;
            pass_d      = '0;
            gray_d      = gray_in;
            // a request for zero passes runs a single pass
            last_pass_d = (passes_in == 4'd0) ? 4'd0 : passes_in - 4'd1;
        end else if (step) begin
            idx_d = idx_q + 5'd1;
            if (last_vector) begin
                pass_d = pass_q + 4'd1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            idx_q       <= '0;
            pass_q      <= '0;
            gray_q      <= 1'b0;
            last_pass_q <= '0;
        end else begin
            idx_q       <= idx_d;
            pass_q      <= pass_d;
            gray_q      <= gray_d;
            last_pass_q <= last_pass_d;
        end
    end
endmodule

// File: rtl/cell_stim_sequencer.sv
// Sweeps all 32 input vectors of an OAI221 cell, counting mismatches and output toggles.
module cell_stim_sequencer
    import cell_stim_sequencer_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned CNT_W         = 16
) (
    input logic                  CLK,
    input logic                  RSTB,
    cell_stim_sequencer_if.slave bus
);
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES);

    state_e           state_q, state_d;
    logic [3:0]       settle_q, settle_d;
    logic [CNT_W-1:0] mis_q, mis_d;
    logic [CNT_W-1:0] tog_q, tog_d;
    logic             prev_q, prev_d;
    logic             seen_q, seen_d;

    logic       vg_clear, vg_step;
    logic [4:0] vec;
    logic       last_vector, last_pass;
    logic       sample;

    cell_stim_vecgen u_vecgen (
        .CLK         (CLK),
        .RSTB        (RSTB),
        .clear       (vg_clear),
        .step        (vg_step),
        .gray_in     (bus.gray_mode),
        .passes_in   (bus.num_passes),
        .vec         (vec),
        .last_vector (last_vector),
        .last_pass   (last_pass)
    );

    assign sample = (state_q == StRun) && (settle_q == SETTLE_LAST);

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        mis_d    = mis_q;
        tog_d    = tog_q;
        prev_d   = prev_q;
        seen_d   = seen_q;
        vg_clear = 1'b0;
        vg_step  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d  = StRun;
                    settle_d = '0;
                    mis_d    = '0;
                    tog_d    = '0;
                    seen_d   = 1'b0;
                    vg_clear = 1'b1;
                end
            end
            StRun: begin
                // abort wins over a completing sample and leaves counters untouched
                if (bus.abort) begin
                    state_d = StIdle;
                end else if (sample) begin
                    if ((bus.dut_qn != oai221_exp(vec)) && (mis_q != '1)) begin
                        mis_d = mis_q + CNT_W'(1);
                    end
                    if (seen_q && (bus.dut_qn != prev_q) && (tog_q != '1)) begin
                        tog_d = tog_q + CNT_W'(1);
                    end
                    prev_d   = bus.dut_qn;
                    seen_d   = 1'b1;
                    settle_d = '0;
                    if (last_vector && last_pass) begin
                        state_d = StDone;
                    end else begin
                        vg_step = 1'b1;
                    end
                end else begin
                    settle_d = settle_q + 4'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            state_q  <= StIdle;
            settle_q <= '0;
            mis_q    <= '0;
            tog_q    <= '0;
            prev_q   <= 1'b0;
            seen_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            mis_q    <= mis_d;
            tog_q    <= tog_d;
            prev_q   <= prev_d;
            seen_q   <= seen_d;
        end
    end

    assign bus.stim         = (state_q == StRun) ? vec : 5'd0;
    assign bus.busy         = (state_q == StRun);
    assign bus.done         = (state_q == StDone);
    assign bus.mismatch_cnt = mis_q;
    assign bus.toggle_cnt   = tog_q;
endmodule

// File: tb/tb_cell_stim_sequencer.sv
// Scoreboard bench: each run pushes its expected result; a monitor checks it when busy drops.
module tb_cell_stim_sequencer;

    logic CLK  = 1'b0;
    logic RSTB = 1'b0;
    always #5 CLK = ~CLK;

    cell_stim_sequencer_if #(.CNT_W(16)) bus ();
    cell_stim_sequencer_if #(.CNT_W(4))  bus4 ();

    cell_stim_sequencer #(.SETTLE_CYCLES(2), .CNT_W(16)) dut (
        .CLK  (CLK),
        .RSTB (RSTB),
        .bus  (bus.slave)
    );

    cell_stim_sequencer #(.SETTLE_CYCLES(2), .CNT_W(4)) dut4 (
        .CLK  (CLK),
        .RSTB (RSTB),
        .bus  (bus4.slave)
    );

    // cell models: 0 correct OAI221, 1 stuck-1, 2 stuck-0, 3 follows IN1, 4 inverted OAI221
    int   mode = 0;
    logic qn_model;
    always_comb begin
        qn_model = 1'b0;
        case (mode)
            0: qn_model = ~((bus.stim[0] | bus.stim[1]) & bus.stim[4] & (bus.stim[2] | bus.stim[3]));
            1: qn_model = 1'b1;
            2: qn_model = 1'b0;
            3: qn_model = bus.stim[0];
            default: qn_model = (bus.stim[0] | bus.stim[1]) & bus.stim[4]
                                & (bus.stim[2] | bus.stim[3]);
        endcase
    end
    assign bus.dut_qn  = qn_model;
    assign bus4.dut_qn = bus4.stim[0];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    typedef struct {
        string name;
        int    cycles;
        int    done;
        int    mism;
        int    tog;
    } exp_t;
    exp_t sbq[$];

    // monitor: count busy cycles, compare the whole result when busy falls
    initial begin
        int   cyc = 0;
        bit   was = 1'b0;
        exp_t e;
        forever begin
            @(negedge CLK);
            if (bus.busy) begin
                cyc++;
                was = 1'b1;
            end else if (was) begin
                was = 1'b0;
                if (sbq.size() == 0) begin
                    n_chk++;
                    $display("FAIL sb_underflow: run ended with no expected entry, cycles %0d", cyc);
                end else begin
                    e = sbq.pop_front();
                    chk({e.name, "_cycles"}, cyc, e.cycles);
                    chk({e.name, "_done"}, int'(bus.done), e.done);
                    chk({e.name, "_mismatch"}, int'(bus.mismatch_cnt), e.mism);
                    chk({e.name, "_toggle"}, int'(bus.toggle_cnt), e.tog);
                    chk({e.name, "_stim_idle"}, int'(bus.stim), 0);
                end
                cyc = 0;
            end
        end
    end

    task automatic push(input string name, input int cyc, input int dn, input int mm, input int tg);
        exp_t e;
        e.name   = name;
        e.cycles = cyc;
        e.done   = dn;
        e.mism   = mm;
        e.tog    = tg;
        sbq.push_back(e);
    endtask

    task automatic start_run(input int m, input bit g, input int np);
        @(negedge CLK);
        mode           = m;
        bus.gray_mode  = g;
        bus.num_passes = 4'(np);
        bus.start      = 1'b1;
        @(negedge CLK);
        bus.start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int limit);
        int n = 0;
        while (bus.busy && n < limit) begin
            @(negedge CLK);
            n++;
        end
        if (bus.busy) begin
            n_chk++;
            $display("FAIL %s_timeout: still busy after %0d cycles, required idle", name, limit);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required $finish first");
        $fatal(1);
    end

    initial begin
        int n;
        bus.start       = 1'b0;
        bus.abort       = 1'b0;
        bus.gray_mode   = 1'b0;
        bus.num_passes  = 4'd1;
        bus4.start      = 1'b0;
        bus4.abort      = 1'b0;
        bus4.gray_mode  = 1'b0;
        bus4.num_passes = 4'd1;

        repeat (2) @(negedge CLK);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_stim", int'(bus.stim), 0);
        chk("rst_mismatch", int'(bus.mismatch_cnt), 0);
        chk("rst_toggle", int'(bus.toggle_cnt), 0);
        RSTB = 1'b1;

        // correct cell, binary order: 5 output transitions over the sweep
        push("s1", 96, 1, 0, 5);
        start_run(0, 1'b0, 1);
        wait_idle("s1", 300);

        // stuck-1: the 9 vectors with expected 0 mismatch
        push("s2", 96, 1, 9, 0);
        start_run(1, 1'b0, 1);
        wait_idle("s2", 300);
        repeat (3) @(negedge CLK);
        chk("s2_hold_mismatch", int'(bus.mismatch_cnt), 9);
        chk("s2_hold_busy", int'(bus.busy), 0);

        // stuck-0, Gray, two passes: 23 mismatches per pass
        push("s3", 192, 1, 46, 0);
        start_run(2, 1'b1, 2);
        wait_idle("s3", 500);

        // zero passes behaves as one; start during RUN and DONE is ignored
        push("s4", 96, 1, 9, 0);
        start_run(1, 1'b0, 0);
        repeat (40) @(negedge CLK);
        bus.start = 1'b1;
        @(negedge CLK);
        bus.start = 1'b0;
        n = 0;
        while (!bus.done && n < 200) begin
            @(negedge CLK);
            n++;
        end
        chk("s4_done_seen", int'(bus.done), 1);
        bus.start = 1'b1;
        @(negedge CLK);
        bus.start = 1'b0;
        chk("s4_no_restart", int'(bus.busy), 0);

        // abort at RUN cycle 10 after three samples (idx 0,1,2)
        push("s5", 11, 0, 2, 2);
        start_run(3, 1'b0, 1);
        repeat (10) @(negedge CLK);
        bus.abort = 1'b1;
        @(negedge CLK);
        bus.abort = 1'b0;
        chk("s5_idle", int'(bus.busy), 0);
        repeat (3) @(negedge CLK);
        chk("s5_hold_mismatch", int'(bus.mismatch_cnt), 2);
        chk("s5_hold_toggle", int'(bus.toggle_cnt), 2);

        // reset mid-run clears everything at once
        push("s6", 21, 0, 0, 0);
        start_run(4, 1'b0, 1);
        repeat (20) @(negedge CLK);
        #2 RSTB = 1'b0;
        #1;
        chk("s6_rst_busy", int'(bus.busy), 0);
        chk("s6_rst_done", int'(bus.done), 0);
        chk("s6_rst_stim", int'(bus.stim), 0);
        chk("s6_rst_mismatch", int'(bus.mismatch_cnt), 0);
        chk("s6_rst_toggle", int'(bus.toggle_cnt), 0);
        repeat (3) @(negedge CLK);
        RSTB = 1'b1;

        // 4-bit counters: 31 toggles and 19 mismatches both saturate at 15
        @(negedge CLK);
        bus4.start = 1'b1;
        @(negedge CLK);
        bus4.start = 1'b0;
        n = 0;
        while (!bus4.done && n < 300) begin
            @(negedge CLK);
            n++;
        end
        chk("s7_done", int'(bus4.done), 1);
        chk("s7_toggle_sat", int'(bus4.toggle_cnt), 15);
        chk("s7_mismatch_sat", int'(bus4.mismatch_cnt), 15);

        repeat (2) @(negedge CLK);
        chk("sb_empty", sbq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/cell_stim_sequencer.md
CELL_STIM_SEQUENCER -- requirements
Module: cell_stim_sequencer

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2: cycles each stimulus vector is held before sampling; legal range 0..15.
REQ-002 Parameter CNT_W, default 16: width of the mismatch and toggle counters.
REQ-003 Port CLK  input  1  single clock; all state updates on the rising edge.
REQ-004 Port RSTB  input  1  reset, asynchronous, active-low.
REQ-005 Port start  input  1  request one test run; sampled only in IDLE.
REQ-006 Port abort  input  1  terminate the run in progress.
REQ-007 Port gray_mode  input  1  vector order: 0 = binary, 1 = Gray; captured at start.
REQ-008 Port num_passes  input  4  full 32-vector sweeps per run; captured at start; 0 is treated as 1.
REQ-009 Port stim  output  5  drives the cell under test; stim[0..4] = IN1..IN5.
REQ-010 Port dut_qn  input  1  QN returned by the OAI221-type cell under test.
REQ-011 Port busy  output  1  high while in RUN.
REQ-012 Port done  output  1  one-cycle pulse on normal completion.
REQ-013 Port mismatch_cnt  output  CNT_W  count of samples where dut_qn differs from the expected value.
REQ-014 Port toggle_cnt  output  CNT_W  count of dut_qn transitions between consecutive samples.

Function
REQ-015 The FSM SHALL have states IDLE, RUN and DONE.
REQ-016 Transitions SHALL be: IDLE->RUN on start; RUN->DONE after the last sample of the last pass; DONE->IDLE unconditionally after one cycle; RUN->IDLE on abort.
REQ-017 On start, the block SHALL clear mismatch_cnt, toggle_cnt and the vector index, set the pass count to 0, and capture gray_mode and num_passes.
REQ-018 In RUN, stim SHALL be idx in binary mode, or idx^(idx>>1) in Gray mode, where idx is the 5-bit vector index.
REQ-019 Each vector SHALL be held for SETTLE_CYCLES+1 cycles; dut_qn SHALL be sampled on the last of those cycles.
REQ-020 The expected value SHALL be ~((IN1|IN2) & IN5 & (IN3|IN4)), computed from the stim value in effect.
REQ-021 On each sample, mismatch_cnt SHALL increment if dut_qn differs from the expected value.
REQ-022 On each sample after the first of a run, toggle_cnt SHALL increment if dut_qn differs from the previous sample.
REQ-023 Both counters SHALL saturate at all-ones and never wrap.
REQ-024 idx SHALL wrap from 31 to 0 and increment the pass count; a run SHALL last exactly max(num_passes,1)*32*(SETTLE_CYCLES+1) cycles in RUN.
REQ-025 stim SHALL be 0 in IDLE and in DONE.
REQ-026 start SHALL be ignored while in RUN or DONE.
REQ-027 abort SHALL take priority over completion in the same cycle.
REQ-028 On abort, the block SHALL return to IDLE with no done pulse and SHALL hold the counters at their partial values.
REQ-029 Counters SHALL hold their values in IDLE until the next accepted start.

Reset
REQ-030 While RSTB is low: state = IDLE, stim = 0, busy = 0, done = 0, both counters = 0, idx = 0, pass count = 0, settle counter = 0.
REQ-031 Asserting RSTB mid-run SHALL abandon the run immediately with no done pulse.

Structure
REQ-032 A shared package SHALL hold the state enum (IDLE/RUN/DONE), the vector count constant (32) and the expected-function helper for OAI221.
REQ-033 One sub-module, cell_stim_vecgen, SHALL contain idx, the binary/Gray mapping and the pass count, exposing last_vector and last_pass flags.

Verification
REQ-034 Bench scenario: correct OAI221 model, binary, 1 pass, SETTLE_CYCLES=2 -> busy for 96 cycles, done pulse, mismatch_cnt = 0.
REQ-035 Bench scenario: dut_qn stuck at 1, binary, 1 pass -> mismatch_cnt = 9, toggle_cnt = 0.
REQ-036 Bench scenario: dut_qn stuck at 0, Gray, num_passes = 2 -> mismatch_cnt = 46, busy for 192 cycles.
REQ-037 Bench scenario: num_passes = 0 -> behaves as 1 pass (96 cycles); start pulsed while busy -> no restart.
REQ-038 Bench scenario: abort at RUN cycle 10 -> IDLE next cycle, stim = 0, no done, counters hold their partial values.
REQ-039 Bench scenario: RSTB low mid-run -> all outputs 0 at once; toggle_cnt saturates with CNT_W = 4 and an alternating dut_qn.
